// File: rtl/order_fill_tracker.sv
// order_fill_tracker: live-order table keyed by ClOrdID. Matches execution reports against
// live slots, emits de-duplicated fills with leaves qty, retires slots on fill, cancel,
// reject or age-out, and backpressures the order manager when every slot is in use.
module order_fill_tracker #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ID_W    = 64,
  parameter int unsigned QTY_W   = 32,
  parameter int unsigned PX_W    = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [ID_W-1:0]            sent_clordid,
  input  logic [QTY_W-1:0]           sent_qty,
  input  logic [PX_W-1:0]            sent_price,
  input  logic                       order_sent_valid,
  output logic                       order_sent_ready,
  input  logic [ID_W-1:0]            exec_clordid,
  input  logic [7:0]                 exec_type,
  input  logic [7:0]                 order_status,
  input  logic [QTY_W-1:0]           cum_qty,
  input  logic [QTY_W-1:0]           last_qty,
  input  logic [PX_W-1:0]            last_price,
  input  logic                       exec_report_valid,
  output logic                       fill_valid,
  output logic [ID_W-1:0]            fill_clordid,
  output logic [QTY_W-1:0]           fill_qty,
  output logic [PX_W-1:0]            fill_price,
  output logic [QTY_W-1:0]           fill_leaves_qty,
  output logic                       order_complete,
  output logic                       order_expired,
  output logic [ID_W-1:0]            expired_clordid,
  output logic                       table_full,
  output logic [$clog2(DEPTH+1)-1:0] active_count,
  output logic [31:0]                matched_count,
  output logic [31:0]                unmatched_count,
  output logic [31:0]                duplicate_count,
  output logic [31:0]                overfill_count,
  output logic [31:0]                reject_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  localparam logic [7:0] EXEC_CANCELED = 8'h34;
  localparam logic [7:0] EXEC_REJECTED = 8'h38;
  localparam logic [7:0] STATUS_FILLED = 8'h32;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Per-slot table
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [ID_W-1:0]  id_q     [DEPTH];
  logic [ID_W-1:0]  id_d     [DEPTH];
  logic [QTY_W-1:0] qty_q    [DEPTH];
  logic [QTY_W-1:0] qty_d    [DEPTH];
  logic [QTY_W-1:0] filled_q [DEPTH];
  logic [QTY_W-1:0] filled_d [DEPTH];
  logic [AGE_W-1:0] age_q    [DEPTH];
  logic [AGE_W-1:0] age_d    [DEPTH];

  // Registered outputs
  logic             fill_valid_q, fill_valid_d;
  logic [ID_W-1:0]  fill_id_q, fill_id_d;
  logic [QTY_W-1:0] fill_qty_q, fill_qty_d;
  logic [PX_W-1:0]  fill_px_q, fill_px_d;
  logic [QTY_W-1:0] leaves_q, leaves_d;
  logic             complete_q, complete_d;
  logic             expired_q, expired_d;
  logic [ID_W-1:0]  expired_id_q, expired_id_d;
  logic             full_q, full_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      matched_q, matched_d;
  logic [31:0]      unmatched_q, unmatched_d;
  logic [31:0]      duplicate_q, duplicate_d;
  logic [31:0]      overfill_q, overfill_d;
  logic [31:0]      reject_q, reject_d;

  // Lookup results against the pre-cycle table
  logic             hit, exec_hit, dup, have_free, exp_hit;
  logic [IDX_W-1:0] hit_idx, free_idx, exp_idx;

  // Order price is accepted on the interface but plays no part in reconciliation.
  logic unused_price;
  assign unused_price = ^sent_price;

  // Search the pre-cycle table: exec match, duplicate insert id, lowest free slot, expiry.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    dup       = 1'b0;
    have_free = 1'b0;
    free_idx  = '0;
    exp_hit   = 1'b0;
    exp_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && valid_q[i] && (id_q[i] == exec_clordid)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (valid_q[i] && (id_q[i] == sent_clordid)) begin
        dup = 1'b1;
      end
      if (!have_free && !valid_q[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
    exec_hit = exec_report_valid && hit;
    // A slot touched by an exec report this cycle never expires in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      if ((TIMEOUT > 0) && !exp_hit && valid_q[i] && (age_q[i] == AGE_MAX) &&
          !(exec_hit && (hit_idx == IDX_W'(i)))) begin
        exp_hit = 1'b1;
        exp_idx = IDX_W'(i);
      end
    end
  end

  // Next-state: aging, exec handling, expiry, insertion, occupancy.
  always_comb begin
    valid_d      = valid_q;
    id_d         = id_q;
    qty_d        = qty_q;
    filled_d     = filled_q;
    age_d        = age_q;
    fill_valid_d = 1'b0;
    complete_d   = 1'b0;
    expired_d    = 1'b0;
    fill_id_d    = fill_id_q;
    fill_qty_d   = fill_qty_q;
    fill_px_d    = fill_px_q;
    leaves_d     = leaves_q;
    expired_id_d = expired_id_q;
    matched_d    = matched_q;
    unmatched_d  = unmatched_q;
    duplicate_d  = duplicate_q;
    overfill_d   = overfill_q;
    reject_d     = reject_q;

    // Ages saturate at TIMEOUT so a slot waiting behind a lower-index expiry stays eligible.
    for (int i = 0; i < DEPTH; i++) begin
      if ((TIMEOUT > 0) && valid_q[i] && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end

    if (exec_report_valid) begin
      if (!hit) begin
        unmatched_d = sat_inc(unmatched_q);
      end else if ((exec_type == EXEC_CANCELED) || (exec_type == EXEC_REJECTED)) begin
        valid_d[hit_idx] = 1'b0;
        complete_d       = 1'b1;
        fill_id_d        = exec_clordid;
        fill_qty_d       = '0;
        fill_px_d        = '0;
        leaves_d         = '0;
      end else if (cum_qty > filled_q[hit_idx]) begin
        fill_valid_d      = 1'b1;
        fill_id_d         = exec_clordid;
        fill_qty_d        = last_qty;
        fill_px_d         = last_price;
        leaves_d          = (qty_q[hit_idx] > cum_qty) ? (qty_q[hit_idx] - cum_qty) : '0;
        filled_d[hit_idx] = cum_qty;
        age_d[hit_idx]    = '0;
        matched_d         = sat_inc(matched_q);
        if (cum_qty > qty_q[hit_idx]) begin
          overfill_d = sat_inc(overfill_q);
        end
        if ((cum_qty >= qty_q[hit_idx]) || (order_status == STATUS_FILLED)) begin
          valid_d[hit_idx] = 1'b0;
          complete_d       = 1'b1;
        end
      end else begin
        duplicate_d = sat_inc(duplicate_q);
      end
    end

    if (exp_hit) begin
      valid_d[exp_idx] = 1'b0;
      expired_d        = 1'b1;
      expired_id_d     = id_q[exp_idx];
    end

    // Insert only into a slot already free before this cycle.
    if (order_sent_valid && order_sent_ready) begin
      if (dup) begin
        reject_d = sat_inc(reject_q);
      end else if (have_free) begin
        valid_d[free_idx]  = 1'b1;
        id_d[free_idx]     = sent_clordid;
        qty_d[free_idx]    = sent_qty;
        filled_d[free_idx] = '0;
        age_d[free_idx]    = '0;
      end
    end

    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
    full_d = (count_d == CNT_W'(DEPTH));
  end

  // State and registered outputs; reset drops the table and any pending pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]     <= '0;
        qty_q[i]    <= '0;
        filled_q[i] <= '0;
        age_q[i]    <= '0;
      end
      fill_valid_q <= 1'b0;
      fill_id_q    <= '0;
      fill_qty_q   <= '0;
      fill_px_q    <= '0;
      leaves_q     <= '0;
      complete_q   <= 1'b0;
      expired_q    <= 1'b0;
      expired_id_q <= '0;
      full_q       <= 1'b0;
      count_q      <= '0;
      matched_q    <= '0;
      unmatched_q  <= '0;
      duplicate_q  <= '0;
      overfill_q   <= '0;
      reject_q     <= '0;
    end else begin
      valid_q      <= valid_d;
      id_q         <= id_d;
      qty_q        <= qty_d;
      filled_q     <= filled_d;
      age_q        <= age_d;
      fill_valid_q <= fill_valid_d;
      fill_id_q    <= fill_id_d;
      fill_qty_q   <= fill_qty_d;
      fill_px_q    <= fill_px_d;
      leaves_q     <= leaves_d;
      complete_q   <= complete_d;
      expired_q    <= expired_d;
      expired_id_q <= expired_id_d;
      full_q       <= full_d;
      count_q      <= count_d;
      matched_q    <= matched_d;
      unmatched_q  <= unmatched_d;
      duplicate_q  <= duplicate_d;
      overfill_q   <= overfill_d;
      reject_q     <= reject_d;
    end
  end

  assign order_sent_ready = !full_q;
  assign fill_valid       = fill_valid_q;
  assign fill_clordid     = fill_id_q;
  assign fill_qty         = fill_qty_q;
  assign fill_price       = fill_px_q;
  assign fill_leaves_qty  = leaves_q;
  assign order_complete   = complete_q;
  assign order_expired    = expired_q;
  assign expired_clordid  = expired_id_q;
  assign table_full       = full_q;
  assign active_count     = count_q;
  assign matched_count    = matched_q;
  assign unmatched_count  = unmatched_q;
  assign duplicate_count  = duplicate_q;
  assign overfill_count   = overfill_q;
  assign reject_count     = reject_q;

endmodule

// File: tb/tb_order_fill_tracker.sv
// Bench for order_fill_tracker: table-driven exec/insert vectors on a no-timeout instance,
// hand-written sequences for table-full reuse, mid-run reset and age-out on a second instance.
module tb_order_fill_tracker;

  localparam logic [7:0] C_F = 8'h46;  // exec type: trade
  localparam logic [7:0] C_0 = 8'h30;
  localparam logic [7:0] C_1 = 8'h31;
  localparam logic [7:0] C_2 = 8'h32;
  localparam logic [7:0] C_4 = 8'h34;
  localparam logic [7:0] C_8 = 8'h38;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] sent_clordid = '0;
  logic [31:0] sent_qty = '0;
  logic [31:0] sent_price = '0;
  logic        order_sent_valid = 1'b0;
  logic [63:0] exec_clordid = '0;
  logic [7:0]  exec_type = '0;
  logic [7:0]  order_status = '0;
  logic [31:0] cum_qty = '0;
  logic [31:0] last_qty = '0;
  logic [31:0] last_price = '0;
  logic        exec_report_valid = 1'b0;

  logic        ready, fill_valid, order_complete, order_expired, table_full;
  logic [63:0] fill_clordid, expired_clordid;
  logic [31:0] fill_qty, fill_price, fill_leaves;
  logic [2:0]  active_count;
  logic [31:0] matched, unmatched, duplicate, overfill, reject;

  logic        to_ready, to_fill_valid, to_complete, to_expired, to_full;
  logic [63:0] to_fill_clordid, to_expired_clordid;
  logic [31:0] to_fill_qty, to_fill_price, to_fill_leaves;
  logic [2:0]  to_active;
  logic [31:0] to_matched, to_unmatched, to_duplicate, to_overfill, to_reject;

  always #5 clk = ~clk;

  order_fill_tracker #(.DEPTH(4), .ID_W(64), .QTY_W(32), .PX_W(32), .TIMEOUT(0)) dut (
    .clk(clk), .rstn(rstn),
    .sent_clordid(sent_clordid), .sent_qty(sent_qty), .sent_price(sent_price),
    .order_sent_valid(order_sent_valid), .order_sent_ready(ready),
    .exec_clordid(exec_clordid), .exec_type(exec_type), .order_status(order_status),
    .cum_qty(cum_qty), .last_qty(last_qty), .last_price(last_price),
    .exec_report_valid(exec_report_valid),
    .fill_valid(fill_valid), .fill_clordid(fill_clordid), .fill_qty(fill_qty),
    .fill_price(fill_price), .fill_leaves_qty(fill_leaves),
    .order_complete(order_complete), .order_expired(order_expired),
    .expired_clordid(expired_clordid), .table_full(table_full), .active_count(active_count),
    .matched_count(matched), .unmatched_count(unmatched), .duplicate_count(duplicate),
    .overfill_count(overfill), .reject_count(reject)
  );

  order_fill_tracker #(.DEPTH(4), .ID_W(64), .QTY_W(32), .PX_W(32), .TIMEOUT(8)) dut_to (
    .clk(clk), .rstn(rstn),
    .sent_clordid(sent_clordid), .sent_qty(sent_qty), .sent_price(sent_price),
    .order_sent_valid(order_sent_valid), .order_sent_ready(to_ready),
    .exec_clordid(exec_clordid), .exec_type(exec_type), .order_status(order_status),
    .cum_qty(cum_qty), .last_qty(last_qty), .last_price(last_price),
    .exec_report_valid(exec_report_valid),
    .fill_valid(to_fill_valid), .fill_clordid(to_fill_clordid), .fill_qty(to_fill_qty),
    .fill_price(to_fill_price), .fill_leaves_qty(to_fill_leaves),
    .order_complete(to_complete), .order_expired(to_expired),
    .expired_clordid(to_expired_clordid), .table_full(to_full), .active_count(to_active),
    .matched_count(to_matched), .unmatched_count(to_unmatched),
    .duplicate_count(to_duplicate), .overfill_count(to_overfill), .reject_count(to_reject)
  );

  typedef struct {
    logic        ins;
    logic [63:0] sid;
    logic [31:0] sqty;
    logic        ex;
    logic [63:0] eid;
    logic [7:0]  ety;
    logic [7:0]  ost;
    logic [31:0] cum, last, px;
    logic        fv, cmp;
    logic [31:0] fq, fp, fl;
    logic [2:0]  act;
    logic        rdy, full;
    logic [31:0] m, u, d, o, r;
  } vec_t;

  typedef struct {
    logic [63:0] id;
    int          cyc;
  } exp_t;

  vec_t sb[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  logic dut_exp_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t stim(input logic ins, input logic [63:0] sid, input logic [31:0] sqty,
                                input logic ex, input logic [63:0] eid, input logic [7:0] ety,
                                input logic [7:0] ost, input logic [31:0] cum,
                                input logic [31:0] last, input logic [31:0] px);
    vec_t v;
    v = '{default: '0};
    v.ins = ins; v.sid = sid; v.sqty = sqty;
    v.ex = ex; v.eid = eid; v.ety = ety; v.ost = ost;
    v.cum = cum; v.last = last; v.px = px;
    return v;
  endfunction

  function automatic vec_t expect_out(input vec_t vi, input logic fv, input logic cmp,
                                      input logic [31:0] fq, input logic [31:0] fp,
                                      input logic [31:0] fl, input logic [2:0] act,
                                      input logic rdy, input logic full,
                                      input logic [31:0] m, input logic [31:0] u,
                                      input logic [31:0] d, input logic [31:0] o,
                                      input logic [31:0] r);
    vec_t v;
    v = vi;
    v.fv = fv; v.cmp = cmp; v.fq = fq; v.fp = fp; v.fl = fl;
    v.act = act; v.rdy = rdy; v.full = full;
    v.m = m; v.u = u; v.d = d; v.o = o; v.r = r;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    order_sent_valid = v.ins; sent_clordid = v.sid; sent_qty = v.sqty; sent_price = 32'd7;
    exec_report_valid = v.ex; exec_clordid = v.eid; exec_type = v.ety;
    order_status = v.ost; cum_qty = v.cum; last_qty = v.last; last_price = v.px;
    sb.push_back(v);
    @(posedge clk);
    #1;
    order_sent_valid = 1'b0;
    exec_report_valid = 1'b0;
    e = sb.pop_front();
    check({tag, ".fill_valid"}, fill_valid, e.fv);
    check({tag, ".complete"}, order_complete, e.cmp);
    if (e.fv) begin
      check({tag, ".fill_qty"}, fill_qty, e.fq);
      check({tag, ".fill_price"}, fill_price, e.fp);
      check({tag, ".leaves"}, fill_leaves, e.fl);
    end
    if (e.fv || e.cmp) check({tag, ".fill_id"}, fill_clordid, e.eid);
    check({tag, ".active"}, active_count, e.act);
    check({tag, ".ready"}, ready, e.rdy);
    check({tag, ".full"}, table_full, e.full);
    check({tag, ".matched"}, matched, e.m);
    check({tag, ".unmatched"}, unmatched, e.u);
    check({tag, ".duplicate"}, duplicate, e.d);
    check({tag, ".overfill"}, overfill, e.o);
    check({tag, ".reject"}, reject, e.r);
  endtask

  task automatic expect_expiry(input logic [63:0] id, input int cyc);
    exp_t e;
    e.id = id;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Idle cycles from_cyc..to_cyc (cycle 0 = insert edge); match expiries against the queue.
  task automatic watch(input int from_cyc, input int to_cyc);
    exp_t e;
    for (int c = from_cyc; c <= to_cyc; c++) begin
      @(posedge clk);
      #1;
      if (order_expired !== 1'b0) dut_exp_seen = 1'b1;
      if (to_expired === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("expire.unexpected", to_expired_clordid, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("expire.id", to_expired_clordid, e.id);
          check("expire.cycle", c, e.cyc);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[14];
    tbl[0]  = expect_out(stim(1, 64'hA, 100, 0, 0, 0, 0, 0, 0, 0),
                         0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = expect_out(stim(0, 0, 0, 1, 64'hA, C_F, C_0, 40, 40, 500),
                         1, 0, 40, 500, 60, 1, 1, 0, 1, 0, 0, 0, 0);
    tbl[2]  = expect_out(stim(0, 0, 0, 1, 64'hA, C_F, C_1, 40, 40, 500),
                         0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0);
    tbl[3]  = expect_out(stim(0, 0, 0, 1, 64'hA, C_F, C_2, 100, 60, 510),
                         1, 1, 60, 510, 0, 0, 1, 0, 2, 0, 1, 0, 0);
    tbl[4]  = expect_out(stim(0, 0, 0, 1, 64'hA, C_F, C_2, 100, 60, 510),
                         0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 1, 0, 0);
    tbl[5]  = expect_out(stim(1, 64'hB, 100, 1, 64'hB, C_F, C_1, 10, 10, 5),
                         0, 0, 0, 0, 0, 1, 1, 0, 2, 2, 1, 0, 0);
    tbl[6]  = expect_out(stim(1, 64'hB, 100, 0, 0, 0, 0, 0, 0, 0),
                         0, 0, 0, 0, 0, 1, 1, 0, 2, 2, 1, 0, 1);
    tbl[7]  = expect_out(stim(0, 0, 0, 1, 64'hB, C_F, C_1, 120, 120, 700),
                         1, 1, 120, 700, 0, 0, 1, 0, 3, 2, 1, 1, 1);
    tbl[8]  = expect_out(stim(1, 64'hC, 50, 0, 0, 0, 0, 0, 0, 0),
                         0, 0, 0, 0, 0, 1, 1, 0, 3, 2, 1, 1, 1);
    tbl[9]  = expect_out(stim(0, 0, 0, 1, 64'hC, C_4, C_4, 20, 20, 9),
                         0, 1, 0, 0, 0, 0, 1, 0, 3, 2, 1, 1, 1);
    tbl[10] = expect_out(stim(1, 64'hD, 10, 0, 0, 0, 0, 0, 0, 0),
                         0, 0, 0, 0, 0, 1, 1, 0, 3, 2, 1, 1, 1);
    tbl[11] = expect_out(stim(0, 0, 0, 1, 64'hD, C_8, C_8, 0, 0, 0),
                         0, 1, 0, 0, 0, 0, 1, 0, 3, 2, 1, 1, 1);
    tbl[12] = expect_out(stim(1, 64'hE, 100, 0, 0, 0, 0, 0, 0, 0),
                         0, 0, 0, 0, 0, 1, 1, 0, 3, 2, 1, 1, 1);
    tbl[13] = expect_out(stim(0, 0, 0, 1, 64'hE, C_F, C_2, 30, 30, 1),
                         1, 1, 30, 1, 70, 0, 1, 0, 4, 2, 1, 1, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.fill_valid", fill_valid, 0);
    check("rst.complete", order_complete, 0);
    check("rst.expired", order_expired, 0);
    check("rst.full", table_full, 0);
    check("rst.ready", ready, 1);
    check("rst.active", active_count, 0);
    check("rst.fill_id", fill_clordid, 0);
    check("rst.leaves", fill_leaves, 0);
    check("rst.counters", {matched, unmatched} | {duplicate, overfill} | {32'h0, reject}, 0);
    rstn = 1'b1;

    for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("v%0d", i));

    // Fill the table, push an extra insert against backpressure, then free and reuse a slot.
    step(expect_out(stim(1, 64'h10, 10, 0, 0, 0, 0, 0, 0, 0),
                    0, 0, 0, 0, 0, 1, 1, 0, 4, 2, 1, 1, 1), "full1");
    step(expect_out(stim(1, 64'h11, 10, 0, 0, 0, 0, 0, 0, 0),
                    0, 0, 0, 0, 0, 2, 1, 0, 4, 2, 1, 1, 1), "full2");
    step(expect_out(stim(1, 64'h12, 10, 0, 0, 0, 0, 0, 0, 0),
                    0, 0, 0, 0, 0, 3, 1, 0, 4, 2, 1, 1, 1), "full3");
    step(expect_out(stim(1, 64'h13, 10, 0, 0, 0, 0, 0, 0, 0),
                    0, 0, 0, 0, 0, 4, 0, 1, 4, 2, 1, 1, 1), "full4");
    step(expect_out(stim(1, 64'h20, 10, 0, 0, 0, 0, 0, 0, 0),
                    0, 0, 0, 0, 0, 4, 0, 1, 4, 2, 1, 1, 1), "full_extra");
    step(expect_out(stim(0, 0, 0, 1, 64'h20, C_F, C_1, 5, 5, 5),
                    0, 0, 0, 0, 0, 4, 0, 1, 4, 3, 1, 1, 1), "full_extra_gone");
    step(expect_out(stim(0, 0, 0, 1, 64'h11, C_F, C_1, 10, 10, 9),
                    1, 1, 10, 9, 0, 3, 1, 0, 5, 3, 1, 1, 1), "full_free");
    step(expect_out(stim(1, 64'h20, 10, 0, 0, 0, 0, 0, 0, 0),
                    0, 0, 0, 0, 0, 4, 0, 1, 5, 3, 1, 1, 1), "full_reuse");
    step(expect_out(stim(0, 0, 0, 1, 64'h20, C_F, C_1, 4, 4, 3),
                    1, 0, 4, 3, 6, 4, 0, 1, 6, 3, 1, 1, 1), "full_reuse_fill");

    // Reset while the table is full
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst.active", active_count, 0);
    check("mid_rst.ready", ready, 1);
    check("mid_rst.full", table_full, 0);
    check("mid_rst.matched", matched, 0);
    check("mid_rst.unmatched", unmatched, 0);
    rstn = 1'b1;

    // Two orders inserted one cycle apart expire on consecutive cycles, lowest slot first.
    order_sent_valid = 1'b1; sent_clordid = 64'h31; sent_qty = 100;
    @(posedge clk);
    #1;
    sent_clordid = 64'h32;
    @(posedge clk);
    #1;
    order_sent_valid = 1'b0;
    expect_expiry(64'h31, 9);
    expect_expiry(64'h32, 10);
    watch(2, 20);
    check("to.pending_after_pair", exp_q.size(), 0);
    check("to.active_after_pair", to_active, 0);

    // An exec on a slot at its expiry cycle wins and restarts its age.
    order_sent_valid = 1'b1; sent_clordid = 64'h33; sent_qty = 100;
    @(posedge clk);
    #1;
    order_sent_valid = 1'b0;
    watch(1, 8);
    exec_report_valid = 1'b1; exec_clordid = 64'h33; exec_type = C_F; order_status = C_1;
    cum_qty = 10; last_qty = 10; last_price = 77;
    @(posedge clk);
    #1;
    exec_report_valid = 1'b0;
    check("to.race_fill", to_fill_valid, 1);
    check("to.race_no_expiry", to_expired, 0);
    check("to.race_qty", to_fill_qty, 10);
    check("to.race_active", to_active, 1);
    expect_expiry(64'h33, 18);
    watch(10, 24);
    check("to.pending_after_race", exp_q.size(), 0);
    check("to.active_after_race", to_active, 0);
    check("no_expiry_when_disabled", dut_exp_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
